sevenseg_mux: RTL

//  Parametrised multiplexed driver for an N-digit 7-segment+dot display.

---
 rtl/sevenseg_pkg.sv | 19 +
 rtl/sevenseg_timebase.sv | 49 ++++
 rtl/sevenseg_mux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and sizing helpers for the multiplexed seven-segment driver.
package sevenseg_pkg;

    localparam int GLYPH_W = 7;
    localparam int SEG_W   = 8;
    localparam int PWM_W   = 4;

    typedef logic [GLYPH_W-1:0] glyph_t;
    typedef logic [SEG_W-1:0]   seg_t;
    typedef logic [PWM_W-1:0]   level_t;

    localparam level_t BRIGHT_FULL = '1;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_timebase.sv
// Slot, digit-address, frame and PWM counters for the display scanner.
module sevenseg_timebase
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 6250,
    parameter int FRAME_W     = 6,
    parameter int AW          = cnt_width(DIGITS),
    parameter int SW          = cnt_width(SLOT_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [SW-1:0]      slot_cnt,
    output logic [AW-1:0]      addr,
    output level_t             pwm_cnt,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               boundary
);

    logic slot_wrap;
    logic addr_wrap;

    assign slot_wrap = (slot_cnt == SW'(SLOT_CYCLES - 1));
    assign addr_wrap = (addr == AW'(DIGITS - 1));
    assign boundary  = (slot_cnt == '0) && (addr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            addr      <= '0;
            pwm_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (slot_wrap) begin
                slot_cnt <= '0;
                if (addr_wrap) begin
                    addr      <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevenseg_mux.sv
// N-digit multiplexed 7-segment driver: double-buffered data, blanking,
// global PWM brightness and per-digit blink, with registered pin outputs.
module sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int DIGITS            = 4,
    parameter int SLOT_CYCLES       = 6250,
    parameter int BLANK_CYCLES      = 64,
    parameter int BLINK_FRAMES_LOG2 = 6,
    parameter bit DIG_ACTIVE_LOW    = 1'b1,
    parameter bit SEG_ACTIVE_LOW    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [GLYPH_W*DIGITS-1:0] digs,
    input  logic [DIGITS-1:0]       dots,
    input  logic [DIGITS-1:0]       blink,
    input  logic                    load,
    input  logic [PWM_W-1:0]        bright,
    output logic [DIGITS-1:0]       dig,
    output logic [SEG_W-1:0]        seg,
    output logic                    frame
);

    localparam int AW = cnt_width(DIGITS);
    localparam int SW = cnt_width(SLOT_CYCLES);
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};
    localparam seg_t              SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

    logic [SW-1:0]                slot_cnt;
    logic [AW-1:0]                addr;
    level_t                       pwm_cnt;
    logic [BLINK_FRAMES_LOG2-1:0] frame_cnt;
    logic                         boundary;

    sevenseg_timebase #(
        .DIGITS      (DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .FRAME_W     (BLINK_FRAMES_LOG2),
        .AW          (AW),
        .SW          (SW)
    ) u_timebase (
        .clk       (clk),
        .reset     (reset),
        .slot_cnt  (slot_cnt),
        .addr      (addr),
        .pwm_cnt   (pwm_cnt),
        .frame_cnt (frame_cnt),
        .boundary  (boundary)
    );

    logic [GLYPH_W*DIGITS-1:0] glyph_shd_reg, glyph_act_reg;
    logic [DIGITS-1:0]         dot_shd_reg, dot_act_reg;
    logic [DIGITS-1:0]         blink_shd_reg, blink_act_reg;
    logic [DIGITS-1:0]         dig_reg, dig_next;
    seg_t                      seg_reg, seg_next;
    logic                      frame_reg;

    glyph_t glyph_act [DIGITS];
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
            assign glyph_act[gi] = glyph_act_reg[GLYPH_W*gi +: GLYPH_W];
        end
    endgenerate

    // Blank window at slot start hides the digit/data switchover (anti-ghosting).
    logic blank_ok;
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_ok = 1'b1;
        end else begin : g_blank
            assign blank_ok = (slot_cnt >= SW'(BLANK_CYCLES));
        end
    endgenerate

    logic bright_ok;
    logic blink_off;
    logic lit;
    logic unused_frame_bits;

    assign bright_ok = (bright == BRIGHT_FULL) || (pwm_cnt < bright);
    assign blink_off = blink_act_reg[addr] && frame_cnt[BLINK_FRAMES_LOG2-1];
    assign lit       = blank_ok && bright_ok && !blink_off;
    assign unused_frame_bits = ^frame_cnt;

    always_comb begin
        dig_next = DIG_OFF;
        seg_next = SEG_OFF;
        if (lit) begin
            dig_next = (DIGITS'(1) << addr) ^ DIG_OFF;
            seg_next = {dot_act_reg[addr], glyph_act[addr]} ^ SEG_OFF;
        end
    end

    // A load on the boundary cycle lands in shadow while active takes the old shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            glyph_shd_reg <= '0;
            dot_shd_reg   <= '0;
            blink_shd_reg <= '0;
            glyph_act_reg <= '0;
            dot_act_reg   <= '0;
            blink_act_reg <= '0;
            dig_reg       <= DIG_OFF;
            seg_reg       <= SEG_OFF;
            frame_reg     <= 1'b0;
        end else begin
            if (load) begin
                glyph_shd_reg <= digs;
                dot_shd_reg   <= dots;
                blink_shd_reg <= blink;
            end
            if (boundary) begin
                glyph_act_reg <= glyph_shd_reg;
                dot_act_reg   <= dot_shd_reg;
                blink_act_reg <= blink_shd_reg;
            end
            dig_reg   <= dig_next;
            seg_reg   <= seg_next;
            frame_reg <= boundary;
        end
    end

    assign dig   = dig_reg;
    assign seg   = seg_reg;
    assign frame = frame_reg;

endmodule
